// File: rtl/data_path_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package  : data_path_pkg                                             |
// | Purpose  : Shared widths, register count and function-select codes   |
// |            for the data path and its function unit.                  |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package data_path_pkg;

   // Datapath geometry
   localparam int DATA_W    = 4;
   localparam int REG_COUNT = 16;
   localparam int SEL_W     = 4;
   localparam int ADDR_W    = 6;
   localparam int FS_W      = 4;

   // Function-select opcodes
   localparam logic [FS_W-1:0] FS_MOVA  = 4'b0000;  // A
   localparam logic [FS_W-1:0] FS_INC   = 4'b0001;  // A + 1
   localparam logic [FS_W-1:0] FS_ADD   = 4'b0010;  // A + B
   localparam logic [FS_W-1:0] FS_ADDI  = 4'b0011;  // A + B + 1
   localparam logic [FS_W-1:0] FS_ADDNB = 4'b0100;  // A + ~B
   localparam logic [FS_W-1:0] FS_SUB   = 4'b0101;  // A - B
   localparam logic [FS_W-1:0] FS_DEC   = 4'b0110;  // A - 1
   localparam logic [FS_W-1:0] FS_MOVA2 = 4'b0111;  // A (alias)
   localparam logic [FS_W-1:0] FS_AND   = 4'b1000;  // A & B
   localparam logic [FS_W-1:0] FS_OR    = 4'b1001;  // A | B
   localparam logic [FS_W-1:0] FS_XOR   = 4'b1010;  // A ^ B
   localparam logic [FS_W-1:0] FS_NOT   = 4'b1011;  // ~A
   localparam logic [FS_W-1:0] FS_MOVB  = 4'b1100;  // B
   localparam logic [FS_W-1:0] FS_SHR   = 4'b1101;  // B >> 1 (logical)
   localparam logic [FS_W-1:0] FS_SHL   = 4'b1110;  // B << 1
   localparam logic [FS_W-1:0] FS_ZERO  = 4'b1111;  // constant zero

   // Widen a data word to a memory address with zeros in the upper bits
   function automatic logic [ADDR_W-1:0] zext_addr(input logic [DATA_W-1:0] v);
      return {{(ADDR_W-DATA_W){1'b0}}, v};
   endfunction

endpackage
`default_nettype wire

// File: rtl/data_path_function_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : function_unit                                             |
// | Purpose  : Combinational 4-bit ALU/shifter selected by FS. All       |
// |            arithmetic wraps modulo 16; carry-out is dropped.          |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module function_unit
   import data_path_pkg::*;
(
   input  logic [DATA_W-1:0] A,
   input  logic [DATA_W-1:0] B,
   input  logic [FS_W-1:0]   FS,
   output logic [DATA_W-1:0] F
);

   localparam logic [DATA_W-1:0] c_one = 4'd1;

   // Select the operation; sums are sized to DATA_W so they wrap naturally
   always_comb begin
      F = '0;
      case (FS)
         FS_MOVA  : F = A;
         FS_INC   : F = A + c_one;
         FS_ADD   : F = A + B;
         FS_ADDI  : F = A + B + c_one;
         FS_ADDNB : F = A + ~B;
         FS_SUB   : F = A + ~B + c_one;
         FS_DEC   : F = A - c_one;
         FS_MOVA2 : F = A;
         FS_AND   : F = A & B;
         FS_OR    : F = A | B;
         FS_XOR   : F = A ^ B;
         FS_NOT   : F = ~A;
         FS_MOVB  : F = B;
         FS_SHR   : F = B >> 1;
         FS_SHL   : F = B << 1;
         FS_ZERO  : F = '0;
         default  : F = '0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/data_path.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : data_path                                                 |
// | Purpose  : 16 x 4-bit register file, bus-B/write-back/address muxes  |
// |            and the function unit. Everything except the register     |
// |            array is combinational.                                   |
// | Config   : DP_ZERO_REG_EN - when defined, R0 is hard-wired to zero   |
// |            and writes to it are discarded.                           |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module data_path
   import data_path_pkg::*;
(
   input  logic                clk_main,
   input  logic                reset,
   input  logic [SEL_W-1:0]    DR,
   input  logic [SEL_W-1:0]    SA,
   input  logic [SEL_W-1:0]    SB,
   input  logic [FS_W-1:0]     FS,
   input  logic                MB,
   input  logic                MD,
   input  logic                RW,
   input  logic                MM,
   input  logic                MW,
   input  logic [ADDR_W-1:0]   PC,
   input  logic [DATA_W-1:0]   DataIn,
   output logic [DATA_W-1:0]   BusA,
   output logic                Z,
   output logic [ADDR_W-1:0]   AddrOut,
   output logic [DATA_W-1:0]   DataOut,
   output logic                MemWrite
);

   logic [DATA_W-1:0] r_regs [REG_COUNT];
   logic [DATA_W-1:0] w_rd_a;
   logic [DATA_W-1:0] w_rd_b;
   logic [DATA_W-1:0] w_bus_b;
   logic [DATA_W-1:0] w_f;
   logic [DATA_W-1:0] w_wb;
   logic              w_wr_en;

`ifdef DP_ZERO_REG_EN
   // R0 is a constant: suppress writes to it and force its reads to zero
   assign w_wr_en = RW && (DR != '0);
   assign w_rd_a  = (SA == '0) ? '0 : r_regs[SA];
   assign w_rd_b  = (SB == '0) ? '0 : r_regs[SB];
`else
   assign w_wr_en = RW;
   assign w_rd_a  = r_regs[SA];
   assign w_rd_b  = r_regs[SB];
`endif

   // Bus B carries either a register or the zero-extended SB field
   assign w_bus_b = MB ? SB : w_rd_b;

   function_unit u_function_unit (
      .A  (w_rd_a),
      .B  (w_bus_b),
      .FS (FS),
      .F  (w_f)
   );

   // Write-back source: function result or memory read data
   assign w_wb = MD ? DataIn : w_f;

   // Register array: cleared asynchronously, one synchronous write port.
   // Reads are combinational from the array, so a same-cycle read of the
   // destination returns the old value (no forwarding).
   always_ff @(posedge clk_main or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < REG_COUNT; i++) begin
            r_regs[i] <= '0;
         end
      end else if (w_wr_en) begin
         r_regs[DR] <= w_wb;
      end
   end

   assign BusA     = w_rd_a;
   assign Z        = (w_f == '0);
   assign AddrOut  = MM ? PC : zext_addr(w_rd_a);
   assign DataOut  = w_bus_b;
   assign MemWrite = MW;

endmodule
`default_nettype wire

// File: tb/tb_data_path.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_data_path                                              |
// | Purpose  : Directed self-checking bench for data_path. Stimulus       |
// |            queues hand-computed expectations; a negedge monitor       |
// |            pops and compares them against the DUT outputs.            |
// | Config   : DP_ZERO_REG_EN selects the expected R0 behaviour.         |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_data_path;

   logic       clk_main = 1'b0;
   logic       reset;
   logic [3:0] DR, SA, SB, FS;
   logic       MB, MD, RW, MM, MW;
   logic [5:0] PC;
   logic [3:0] DataIn;
   logic [3:0] BusA;
   logic       Z;
   logic [5:0] AddrOut;
   logic [3:0] DataOut;
   logic       MemWrite;

   data_path dut (
      .clk_main (clk_main),
      .reset    (reset),
      .DR       (DR),
      .SA       (SA),
      .SB       (SB),
      .FS       (FS),
      .MB       (MB),
      .MD       (MD),
      .RW       (RW),
      .MM       (MM),
      .MW       (MW),
      .PC       (PC),
      .DataIn   (DataIn),
      .BusA     (BusA),
      .Z        (Z),
      .AddrOut  (AddrOut),
      .DataOut  (DataOut),
      .MemWrite (MemWrite)
   );

   always #5 clk_main = ~clk_main;

   typedef struct packed {
      logic [3:0] busa;
      logic       z;
      logic [5:0] addr;
      logic [3:0] dout;
      logic       mw;
   } exp_t;

   exp_t  exp_q[$];
   string name_q[$];
   int    errors = 0;
   int    checks = 0;
   exp_t  m_e;
   string m_nm;

   task automatic cmp(input string nm, input string fld, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s.%s actual=%0h required=%0h", nm, fld, act, req);
      end
   endtask

   // Monitor: one expectation is queued per cycle, compared mid-cycle
   always @(negedge clk_main) begin
      if (exp_q.size() > 0) begin
         m_e  = exp_q.pop_front();
         m_nm = name_q.pop_front();
         cmp(m_nm, "BusA",     int'(BusA),     int'(m_e.busa));
         cmp(m_nm, "Z",        int'(Z),        int'(m_e.z));
         cmp(m_nm, "AddrOut",  int'(AddrOut),  int'(m_e.addr));
         cmp(m_nm, "DataOut",  int'(DataOut),  int'(m_e.dout));
         cmp(m_nm, "MemWrite", int'(MemWrite), int'(m_e.mw));
      end
   end

   task automatic drive(input logic [3:0] dr, input logic [3:0] sa, input logic [3:0] sb,
                        input logic [3:0] fs, input logic mb, input logic md, input logic rw,
                        input logic mm, input logic mw, input logic [5:0] pc, input logic [3:0] din);
      DR = dr; SA = sa; SB = sb; FS = fs; MB = mb; MD = md; RW = rw;
      MM = mm; MW = mw; PC = pc; DataIn = din;
   endtask

   // Queue the expected outputs for the current inputs, then advance a cycle
   task automatic expect_out(input string nm, input logic [3:0] busa, input logic z,
                             input logic [5:0] addr, input logic [3:0] dout, input logic mw);
      exp_t e;
      e = '{busa: busa, z: z, addr: addr, dout: dout, mw: mw};
      exp_q.push_back(e);
      name_q.push_back(nm);
      @(posedge clk_main);
      #1;
   endtask

   // Expected F for A=4'hC, B=4'hA, indexed by FS
   logic [3:0] fexp_tab [16];
   logic [3:0] fe;

   initial begin
      fexp_tab = '{4'hC, 4'hD, 4'h6, 4'h7, 4'h1, 4'h2, 4'hB, 4'hC,
                   4'h8, 4'hE, 4'h6, 4'h3, 4'hA, 4'h5, 4'h4, 4'h0};

      // Reset held with a write pending: every register reads zero
      reset = 1'b1;
      drive(4'd3, 4'd0, 4'd0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'h00, 4'hF);
      @(posedge clk_main);
      #1;
      for (int i = 0; i < 16; i++) begin
         SA = i[3:0];
         expect_out($sformatf("rst_sa%0d", i), 4'h0, 1'b1, 6'h00, 4'h0, 1'b0);
      end

      // Release reset mid-cycle
      reset = 1'b0;
      drive(4'd0, 4'd0, 4'd0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 4'h0);
      expect_out("post_rst", 4'h0, 1'b1, 6'h00, 4'h0, 1'b0);

      // Load immediate and read back
      drive(4'd3, 4'd0, 4'h9, 4'hC, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'h00, 4'h0);
      expect_out("ldi_r3", 4'h0, 1'b0, 6'h00, 4'h9, 1'b0);
      drive(4'd0, 4'd3, 4'd0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 4'h0);
      expect_out("rd_r3", 4'h9, 1'b0, 6'h09, 4'h0, 1'b0);

      // RW=0 leaves the register unchanged
      drive(4'd3, 4'd0, 4'hF, 4'hC, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 4'h0);
      expect_out("nowr", 4'h0, 1'b0, 6'h00, 4'hF, 1'b0);
      drive(4'd0, 4'd3, 4'd0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 4'h0);
      expect_out("rd_r3_kept", 4'h9, 1'b0, 6'h09, 4'h0, 1'b0);

      // Arithmetic wrap: R1=F, R2=1
      drive(4'd1, 4'd0, 4'hF, 4'hC, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'h00, 4'h0);
      expect_out("ldi_r1", 4'h0, 1'b0, 6'h00, 4'hF, 1'b0);
      drive(4'd2, 4'd0, 4'h1, 4'hC, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'h00, 4'h0);
      expect_out("ldi_r2", 4'h0, 1'b0, 6'h00, 4'h1, 1'b0);
      drive(4'd4, 4'd1, 4'd2, 4'h2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'h00, 4'h0);
      expect_out("add_wrap", 4'hF, 1'b1, 6'h0F, 4'h1, 1'b0);
      drive(4'd5, 4'd1, 4'd2, 4'h5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'h00, 4'h0);
      expect_out("sub", 4'hF, 1'b0, 6'h0F, 4'h1, 1'b0);
      drive(4'd0, 4'd4, 4'd0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 4'h0);
      expect_out("rd_r4", 4'h0, 1'b1, 6'h00, 4'h0, 1'b0);
      drive(4'd0, 4'd5, 4'd0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 4'h0);
      expect_out("rd_r5", 4'hE, 1'b0, 6'h0E, 4'h0, 1'b0);

      // Every opcode with A=R9=C, B=immediate A; result lands in R8
      drive(4'd9, 4'd0, 4'hC, 4'hC, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'h00, 4'h0);
      expect_out("ldi_r9", 4'h0, 1'b0, 6'h00, 4'hC, 1'b0);
      for (int i = 0; i < 16; i++) begin
         fe = fexp_tab[i];
         drive(4'd8, 4'd9, 4'hA, i[3:0], 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'h00, 4'h0);
         expect_out($sformatf("op%0d", i), 4'hC, (fe == 4'h0), 6'h0C, 4'hA, 1'b0);
         drive(4'd0, 4'd8, 4'hA, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 4'h0);
         expect_out($sformatf("op%0d_res", i), fe, (fe == 4'h0), {2'b00, fe}, 4'hA, 1'b0);
      end

      // Memory path
      drive(4'd7, 4'd0, 4'd0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'h00, 4'h6);
      expect_out("ld_mem", 4'h0, 1'b1, 6'h00, 4'h0, 1'b0);
      drive(4'd0, 4'd7, 4'd0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 4'h0);
      expect_out("rd_r7", 4'h6, 1'b0, 6'h06, 4'h0, 1'b0);
      drive(4'd10, 4'd0, 4'h5, 4'hC, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'h00, 4'h0);
      expect_out("ldi_r10", 4'h0, 1'b0, 6'h00, 4'h5, 1'b0);
      drive(4'd0, 4'd10, 4'd0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'h2A, 4'h0);
      expect_out("pc_addr", 4'h5, 1'b0, 6'h2A, 4'h0, 1'b0);
      drive(4'd0, 4'd10, 4'd3, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'h2A, 4'h0);
      expect_out("mem_wr", 4'h5, 1'b0, 6'h05, 4'h9, 1'b1);

      // Same-cycle write and read of one register: no forwarding
      drive(4'd5, 4'd0, 4'h8, 4'hC, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'h00, 4'h0);
      expect_out("ldi_r5", 4'h0, 1'b0, 6'h00, 4'h8, 1'b0);
      drive(4'd5, 4'd5, 4'h3, 4'hC, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'h00, 4'h0);
      expect_out("same_pre", 4'h8, 1'b0, 6'h08, 4'h3, 1'b0);
      drive(4'd0, 4'd5, 4'd0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 4'h0);
      expect_out("same_post", 4'h3, 1'b0, 6'h03, 4'h0, 1'b0);

      // R0 write
      drive(4'd0, 4'd0, 4'hA, 4'hC, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'h00, 4'h0);
      expect_out("wr_r0", 4'h0, 1'b0, 6'h00, 4'hA, 1'b0);
      drive(4'd0, 4'd0, 4'd0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 4'h0);
`ifdef DP_ZERO_REG_EN
      expect_out("rd_r0", 4'h0, 1'b1, 6'h00, 4'h0, 1'b0);
`else
      expect_out("rd_r0", 4'hA, 1'b0, 6'h0A, 4'hA, 1'b0);
`endif

      // Asynchronous reset mid-cycle clears before any clock edge
      drive(4'd0, 4'd3, 4'd0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 4'h0);
      reset = 1'b1;
      expect_out("async_rst", 4'h0, 1'b1, 6'h00, 4'h0, 1'b0);
      reset = 1'b0;
      expect_out("rst_rel", 4'h0, 1'b1, 6'h00, 4'h0, 1'b0);
      drive(4'd3, 4'd0, 4'h7, 4'hC, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'h00, 4'h0);
      expect_out("ldi_r3_again", 4'h0, 1'b0, 6'h00, 4'h7, 1'b0);
      drive(4'd0, 4'd3, 4'd0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 4'h0);
      expect_out("rd_r3_again", 4'h7, 1'b0, 6'h07, 4'h0, 1'b0);

      // Let the monitor drain, then confirm nothing was left unchecked
      repeat (2) @(negedge clk_main);
      #1;
      cmp("drain", "pending", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
